// File: rtl/sync_fifo_pkg.sv
// Shared defaults and status bundle for the sync_fifo_flags FIFO.
package sync_fifo_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 16;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// Storage array for sync_fifo_flags: one synchronous write port, one asynchronous read port.
module fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int width = DEF_WIDTH,
  parameter int depth = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(depth)-1:0] i_wr_addr,
  input  logic [width-1:0]         i_wr_data,
  input  logic [$clog2(depth)-1:0] i_rd_addr,
  output logic [width-1:0]         o_rd_data
);

  logic [width-1:0] r_mem [depth];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with full/empty/almost flags and overflow/underflow pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read behaviour.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int width    = DEF_WIDTH,
  parameter int depth    = DEF_DEPTH,
  parameter int af_level = depth - 2,
  parameter int ae_level = 2
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic [width-1:0]       fifo_data_in,
  input  logic                   fifo_write,
  input  logic                   fifo_read,
  output logic [width-1:0]       fifo_data_out,
  output logic                   fifo_full,
  output logic                   fifo_empty,
  output logic                   fifo_almost_full,
  output logic                   fifo_almost_empty,
  output logic [$clog2(depth):0] fifo_count,
  output logic                   fifo_overflow,
  output logic                   fifo_underflow
);

  localparam int AW = $clog2(depth);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(depth);
  localparam logic [AW:0] CNT_AF   = (AW+1)'(af_level);
  localparam logic [AW:0] CNT_AE   = (AW+1)'(ae_level);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      r_cnt;
  logic             r_overflow;
  logic             r_underflow;
  logic             w_wr_ok;
  logic             w_rd_ok;
  logic [width-1:0] w_rd_data;
  logic             w_unused;
  fifo_status_t     w_status;

  always_comb begin
    w_status              = '0;
    w_status.full         = (r_cnt == CNT_FULL);
    w_status.empty        = (r_cnt == '0);
    w_status.almost_full  = (r_cnt >= CNT_AF);
    w_status.almost_empty = (r_cnt <= CNT_AE);
    w_status.overflow     = r_overflow;
    w_status.underflow    = r_underflow;
  end

  // A write while full is only accepted when a read frees the slot in the same cycle.
  assign w_wr_ok = fifo_write && (!w_status.full || fifo_read);
  assign w_rd_ok = fifo_read && !w_status.empty;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + ONE;
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + ONE;
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_cnt <= r_cnt + ONE;
        2'b01:   r_cnt <= r_cnt - ONE;
        default: r_cnt <= r_cnt;
      endcase
      r_overflow  <= fifo_write && w_status.full && !fifo_read;
      r_underflow <= fifo_read && w_status.empty;
    end
  end

  // Occupancy comes from r_cnt; the pointer wrap bits are kept only for debug visibility.
  assign w_unused = ^{r_wr_ptr[AW], r_rd_ptr[AW]};

  fifo_mem #(
    .width(width),
    .depth(depth)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_wr_ok),
    .i_wr_addr (r_wr_ptr[AW-1:0]),
    .i_wr_data (fifo_data_in),
    .i_rd_addr (r_rd_ptr[AW-1:0]),
    .o_rd_data (w_rd_data)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign fifo_data_out = w_status.empty ? '0 : w_rd_data;
`else
  logic [width-1:0] r_data_out;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)        r_data_out <= '0;
    else if (w_rd_ok) r_data_out <= w_rd_data;
  end

  assign fifo_data_out = r_data_out;
`endif

  assign fifo_full         = w_status.full;
  assign fifo_empty        = w_status.empty;
  assign fifo_almost_full  = w_status.almost_full;
  assign fifo_almost_empty = w_status.almost_empty;
  assign fifo_overflow     = w_status.overflow;
  assign fifo_underflow    = w_status.underflow;
  assign fifo_count        = r_cnt;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed self-checking bench for sync_fifo_flags (depth 16, width 16, af 14, ae 2).
module tb_sync_fifo_flags;

`ifdef SYNC_FIFO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_;
  logic [15:0] fifo_data_in;
  logic        fifo_write;
  logic        fifo_read;
  logic [15:0] fifo_data_out;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_almost_full;
  logic        fifo_almost_empty;
  logic [4:0]  fifo_count;
  logic        fifo_overflow;
  logic        fifo_underflow;

  int checks = 0;
  int errors = 0;

  sync_fifo_flags #(
    .width(16),
    .depth(16),
    .af_level(14),
    .ae_level(2)
  ) dut (
    .clk               (clk),
    .rst_              (rst_),
    .fifo_data_in      (fifo_data_in),
    .fifo_write        (fifo_write),
    .fifo_read         (fifo_read),
    .fifo_data_out     (fifo_data_out),
    .fifo_full         (fifo_full),
    .fifo_empty        (fifo_empty),
    .fifo_almost_full  (fifo_almost_full),
    .fifo_almost_empty (fifo_almost_empty),
    .fifo_count        (fifo_count),
    .fifo_overflow     (fifo_overflow),
    .fifo_underflow    (fifo_underflow)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_ = 1'b1; fifo_data_in = '0; fifo_write = 1'b0; fifo_read = 1'b0;
    #1 rst_ = 1'b0;
    #11;
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", fifo_empty); end
    checks++; if (fifo_almost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae: got %b expected 1", fifo_almost_empty); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", fifo_full); end
    checks++; if (fifo_almost_full !== 1'b0) begin errors++; $display("FAIL reset_af: got %b expected 0", fifo_almost_full); end
    checks++; if (fifo_data_out !== 16'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", fifo_data_out); end
    checks++; if (fifo_overflow !== 1'b0 || fifo_underflow !== 1'b0) begin errors++; $display("FAIL reset_pulses: got %b%b expected 00", fifo_overflow, fifo_underflow); end
    #1 rst_ = 1'b1;
    step();
  endtask

  task automatic test_fill();
    fifo_write = 1'b1;
    for (int unsigned i = 0; i < 16; i++) begin
      fifo_data_in = 16'(i);
      step();
      checks++; if (fifo_count !== 5'(i + 1)) begin errors++; $display("FAIL fill_count: got %0d expected %0d", fifo_count, i + 1); end
      checks++; if (fifo_almost_full !== (i + 1 >= 14)) begin errors++; $display("FAIL fill_af: got %b expected %b at count %0d", fifo_almost_full, (i + 1 >= 14), i + 1); end
      checks++; if (fifo_full !== (i + 1 == 16)) begin errors++; $display("FAIL fill_full: got %b expected %b at count %0d", fifo_full, (i + 1 == 16), i + 1); end
      checks++; if (fifo_overflow !== 1'b0) begin errors++; $display("FAIL fill_overflow: got %b expected 0", fifo_overflow); end
    end
    fifo_write = 1'b0;
  endtask

  task automatic test_overflow();
    fifo_write = 1'b1;
    fifo_data_in = 16'd103;
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      checks++; if (fifo_overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b expected 1 (drop %0d)", fifo_overflow, i); end
      checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL ovf_count: got %0d expected 16", fifo_count); end
    end
    fifo_write = 1'b0;
    step();
    checks++; if (fifo_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", fifo_overflow); end
  endtask

  task automatic test_drain();
    logic [15:0] got;
    fifo_read = 1'b1;
    for (int unsigned k = 0; k < 17; k++) begin
      got = '0;
      if (FWFT) got = fifo_data_out;
      step();
      if (!FWFT) got = fifo_data_out;
      if (k < 16) begin
        checks++; if (got !== 16'(k)) begin errors++; $display("FAIL drain_data: got %0d expected %0d", got, k); end
        checks++; if (fifo_count !== 5'(15 - k)) begin errors++; $display("FAIL drain_count: got %0d expected %0d", fifo_count, 15 - k); end
        checks++; if (fifo_almost_empty !== (15 - k <= 2)) begin errors++; $display("FAIL drain_ae: got %b expected %b", fifo_almost_empty, (15 - k <= 2)); end
      end
      checks++; if (fifo_underflow !== (k == 16)) begin errors++; $display("FAIL drain_underflow: got %b expected %b at read %0d", fifo_underflow, (k == 16), k); end
    end
    fifo_read = 1'b0;
    step();
    checks++; if (fifo_underflow !== 1'b0) begin errors++; $display("FAIL unf_clear: got %b expected 0", fifo_underflow); end
    checks++; if (fifo_empty !== 1'b1 || fifo_almost_empty !== 1'b1) begin errors++; $display("FAIL drain_flags: got e=%b ae=%b expected 1 1", fifo_empty, fifo_almost_empty); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] got;
    fifo_write = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      fifo_data_in = 16'(100 + i);
      step();
    end
    checks++; if (fifo_count !== 5'd8) begin errors++; $display("FAIL b2b_prefill: got %0d expected 8", fifo_count); end
    fifo_read = 1'b1;
    for (int unsigned i = 0; i < 40; i++) begin
      fifo_data_in = 16'(108 + i);
      got = '0;
      if (FWFT) got = fifo_data_out;
      step();
      if (!FWFT) got = fifo_data_out;
      checks++; if (got !== 16'(100 + i)) begin errors++; $display("FAIL b2b_data: got %0d expected %0d", got, 100 + i); end
      checks++; if (fifo_count !== 5'd8) begin errors++; $display("FAIL b2b_count: got %0d expected 8", fifo_count); end
    end
    fifo_write = 1'b0;
    fifo_read = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [15:0] got;
    fifo_read = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      got = '0;
      if (FWFT) got = fifo_data_out;
      step();
      if (!FWFT) got = fifo_data_out;
      checks++; if (got !== 16'(140 + i)) begin errors++; $display("FAIL prerst_data: got %0d expected %0d", got, 140 + i); end
    end
    fifo_read = 1'b0;
    checks++; if (fifo_count !== 5'd5) begin errors++; $display("FAIL prerst_count: got %0d expected 5", fifo_count); end
    #3 rst_ = 1'b0;
    #1;
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL arst_count: got %0d expected 0", fifo_count); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL arst_empty: got %b expected 1", fifo_empty); end
    checks++; if (fifo_data_out !== 16'd0) begin errors++; $display("FAIL arst_data: got %0d expected 0", fifo_data_out); end
    fifo_write = 1'b1; fifo_read = 1'b1; fifo_data_in = 16'd99;
    step();
    step();
    checks++; if (fifo_count !== 5'd0 || fifo_overflow !== 1'b0 || fifo_underflow !== 1'b0) begin errors++; $display("FAIL rst_ignore: got cnt=%0d ovf=%b unf=%b expected 0 0 0", fifo_count, fifo_overflow, fifo_underflow); end
    fifo_write = 1'b0; fifo_read = 1'b0;
    rst_ = 1'b1;
    fifo_write = 1'b1; fifo_data_in = 16'd7;
    step();
    fifo_write = 1'b0;
    checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL post_rst_count: got %0d expected 1", fifo_count); end
    fifo_read = 1'b1;
    got = '0;
    if (FWFT) got = fifo_data_out;
    step();
    if (!FWFT) got = fifo_data_out;
    fifo_read = 1'b0;
    checks++; if (got !== 16'd7) begin errors++; $display("FAIL post_rst_data: got %0d expected 7", got); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL post_rst_empty: got %b expected 1", fifo_empty); end
  endtask

  task automatic test_no_bypass();
    logic [15:0] got;
    fifo_write = 1'b1; fifo_read = 1'b1; fifo_data_in = 16'h0055;
    step();
    fifo_write = 1'b0;
    checks++; if (fifo_underflow !== 1'b1) begin errors++; $display("FAIL nobypass_unf: got %b expected 1", fifo_underflow); end
    checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL nobypass_count: got %0d expected 1", fifo_count); end
    got = '0;
    if (FWFT) got = fifo_data_out;
    step();
    if (!FWFT) got = fifo_data_out;
    fifo_read = 1'b0;
    checks++; if (got !== 16'h0055) begin errors++; $display("FAIL nobypass_data: got %0d expected 85", got); end
    checks++; if (fifo_underflow !== 1'b0 || fifo_empty !== 1'b1) begin errors++; $display("FAIL nobypass_end: got unf=%b e=%b expected 0 1", fifo_underflow, fifo_empty); end
  endtask

`ifdef SYNC_FIFO_FWFT_EN
  task automatic test_fwft();
    fifo_write = 1'b1; fifo_data_in = 16'd42;
    step();
    fifo_write = 1'b0;
    checks++; if (fifo_data_out !== 16'd42) begin errors++; $display("FAIL fwft_show: got %0d expected 42", fifo_data_out); end
    step();
    checks++; if (fifo_data_out !== 16'd42 || fifo_empty !== 1'b0) begin errors++; $display("FAIL fwft_hold: got d=%0d e=%b expected 42 0", fifo_data_out, fifo_empty); end
    fifo_read = 1'b1;
    step();
    fifo_read = 1'b0;
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL fwft_empty: got %b expected 1", fifo_empty); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_back_to_back();
    test_async_reset();
    test_no_bypass();
`ifdef SYNC_FIFO_FWFT_EN
    test_fwft();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 SHALL have parameter width, default 16, data bits per word.
REQ-002 SHALL have parameter depth, default 16, number of words; power of two, at least 4.
REQ-003 SHALL have parameter af_level, default depth-2, almost-full threshold in words.
REQ-004 SHALL have parameter ae_level, default 2, almost-empty threshold in words.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port fifo_data_in, input, width, write data.
REQ-008 SHALL have port fifo_write, input, 1, write request.
REQ-009 SHALL have port fifo_read, input, 1, read request.
REQ-010 SHALL have port fifo_data_out, output, width, read data.
REQ-011 SHALL have port fifo_full, output, 1, the count equals depth.
REQ-012 SHALL have port fifo_empty, output, 1, the count equals 0.
REQ-013 SHALL have port fifo_almost_full, output, 1, the count is at least af_level.
REQ-014 SHALL have port fifo_almost_empty, output, 1, the count is at most ae_level.
REQ-015 SHALL have port fifo_count, output, $clog2(depth)+1, the current word count.
REQ-016 SHALL have port fifo_overflow, output, 1, a one-cycle pulse for a dropped write.
REQ-017 SHALL have port fifo_underflow, output, 1, a one-cycle pulse for a dropped read.

Function
REQ-018 SHALL use wr_ptr and rd_ptr of width $clog2(depth)+1; the MSB is a wrap bit; the low bits address mem and wrap from depth-1 to 0.
REQ-019 SHALL accept a write when fifo_write is high and (not full, or fifo_read is high while full).
  - An accepted write stores fifo_data_in at mem[wr_ptr] and increments wr_ptr.
REQ-020 SHALL accept a read when fifo_read is high and the FIFO is not empty.
  - Writes never bypass: a read while empty is dropped even with a simultaneous write.
REQ-021 SHALL update cnt by +1 for a write only, -1 for a read only, and 0 for both or neither.
  - cnt never exceeds depth and never goes below 0.
REQ-022 SHALL, in standard mode, register mem[rd_ptr] to fifo_data_out one cycle after an accepted read.
  - fifo_data_out holds its value otherwise.
REQ-023 SHALL derive fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty and fifo_count combinationally from the registered cnt.
REQ-024 SHALL pulse fifo_overflow high for exactly the cycle after a write is dropped.
  - A write is dropped when it is requested while full with no read.
REQ-025 SHALL pulse fifo_underflow high for exactly the cycle after a read is dropped while empty.
REQ-026 SHALL leave the pointers, cnt and mem unchanged by a dropped request.

Reset
REQ-027 SHALL, while rst_ is low, asynchronously force the following:
  - wr_ptr=0, rd_ptr=0, cnt=0;
  - fifo_data_out=0, fifo_overflow=0, fifo_underflow=0;
  - hence fifo_empty=1, fifo_almost_empty=1, fifo_full=0, fifo_almost_full=0.
REQ-028 SHALL not clear mem on reset.
  - Assertion of rst_ mid-operation discards all stored words.
  - Requests during reset are ignored and do not raise error pulses.

Configuration
REQ-029 SHALL, with macro SYNC_FIFO_FWFT_EN defined, operate first-word-fall-through:
  - fifo_data_out shows mem[rd_ptr] combinationally whenever not empty;
  - the first written word is visible the cycle after its write;
  - fifo_read acknowledges the current word.
REQ-030 SHALL, without SYNC_FIFO_FWFT_EN, operate in the standard registered-read mode of REQ-022.

Structure
REQ-031 SHALL place the default width and depth constants in package sync_fifo_pkg.
REQ-032 SHALL place a typedef for a status struct in sync_fifo_pkg: full, empty, almost_full, almost_empty, overflow, underflow.
REQ-033 SHALL instantiate the storage array as sub-module fifo_mem.
  - fifo_mem has one write port and one asynchronous read port, parametrised by width and depth.

Verification (depth=16, width=16, af_level=14, ae_level=2)
REQ-034 SHALL check: write 0..15 on consecutive cycles.
  - fifo_count reaches 16.
  - fifo_almost_full rises at count 14.
  - fifo_full rises at count 16.
  - No fifo_overflow pulse.
REQ-035 SHALL check: with the FIFO full, write 103 for 3 cycles.
  - Three fifo_overflow pulses.
  - fifo_count stays 16.
  - Subsequent reads return 0..15 in order; 103 is never returned.
REQ-036 SHALL check: read 17 times from full.
  - 16 words are returned, 0..15.
  - Exactly one fifo_underflow pulse.
  - fifo_empty=1 and fifo_almost_empty=1 at the end.
REQ-037 SHALL check: hold write and read together for 40 cycles at count 8.
  - fifo_count stays 8.
  - Data is returned in order across the pointer wrap.
REQ-038 SHALL check: at count 5, drive rst_=0 mid-cycle.
  - Outputs clear immediately: fifo_count=0, fifo_empty=1, fifo_data_out=0.
  - After release, write 7 then read returns 7.
REQ-039 SHALL check, with SYNC_FIFO_FWFT_EN: write 42 into an empty FIFO.
  - fifo_data_out=42 the following cycle with no read.
  - A read then sets fifo_empty=1.
